// File: rtl/cmos_frame_cropper_if.sv
// rtl/cmos_frame_cropper_if.sv - cropped pixel stream with SOF/EOL sideband
interface cmos_frame_cropper_if;
    logic [15:0] oDATA;
    logic        oSOF;
    logic        oEOL;
    logic        oVALID;
    logic        iREADY;

    modport master (output oDATA, oSOF, oEOL, oVALID, input iREADY);
    modport slave  (input oDATA, oSOF, oEOL, oVALID, output iREADY);
endinterface

// File: rtl/cmos_frame_cropper.sv
// rtl/cmos_frame_cropper.sv - crops a fixed window from the CMOS pixel stream into a FWFT FIFO
module cmos_frame_cropper #(
    parameter int H_START    = 0,
    parameter int H_SIZE     = 640,
    parameter int V_START    = 0,
    parameter int V_SIZE     = 480,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iFRAME_VALID,
    input  logic                  iHREF,
    input  logic                  iPIX_EN,
    input  logic [15:0]           iPIX_DATA,
    cmos_frame_cropper_if.master  m_stream,
    output logic                  oFRAME_DONE,
    output logic                  oFRAME_OK,
    output logic                  oOVERFLOW,
    output logic [7:0]            oFRAME_CNT
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [11:0] X_LO   = 12'(H_START);
    localparam logic [11:0] X_SZ   = 12'(H_SIZE);
    localparam logic [11:0] X_LAST = 12'(H_START + H_SIZE - 1);
    localparam logic [11:0] Y_LO   = 12'(V_START);
    localparam logic [11:0] Y_SZ   = 12'(V_SIZE);
    localparam logic [11:0] Y_END  = 12'(V_START + V_SIZE);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {WAIT_IDLE, WAIT_SOF, ACTIVE, DROP} state_t;

    state_t        state_q, state_d;
    logic          fv_q, href_q;
    logic          fv_rise, fv_fall, href_fall;
    logic [11:0]   x_q, x_d, y_q, y_d;
    logic [11:0]   x_off, y_off;
    logic          in_window;
    logic          ovf_d, done_d, ok_d;
    logic [7:0]    cnt_d;
    logic          wr_en;
    logic [17:0]   wr_word;

    logic [17:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_d;
    logic          valid_q;
    logic          rd_en;
    logic [17:0]   head;

    // Edges compare the previous registered sample with the live input so frame/line ends act in the same cycle.
    assign fv_rise   = ~fv_q & iFRAME_VALID;
    assign fv_fall   = fv_q & ~iFRAME_VALID;
    assign href_fall = href_q & ~iHREF;

    // Offsets wrap to large values when below the window start, so one unsigned compare covers both bounds.
    assign x_off     = x_q - X_LO;
    assign y_off     = y_q - Y_LO;
    assign in_window = (x_off < X_SZ) && (y_off < Y_SZ);
    assign wr_word   = {(x_q == X_LO) && (y_q == Y_LO), (x_q == X_LAST), iPIX_DATA};

    // Register the qualifier samples used for edge detection.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            fv_q   <= 1'b0;
            href_q <= 1'b0;
        end else begin
            fv_q   <= iFRAME_VALID;
            href_q <= iHREF;
        end
    end

    // Crop state machine: the pixel is handled first, then line end, then frame end, all in one cycle.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ovf_d   = oOVERFLOW;
        done_d  = 1'b0;
        ok_d    = oFRAME_OK;
        cnt_d   = oFRAME_CNT;
        wr_en   = 1'b0;
        unique case (state_q)
            WAIT_IDLE: begin
                if (!iFRAME_VALID) state_d = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (fv_rise) begin
                    state_d = ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACTIVE: begin
                if (iPIX_EN) begin
                    if (x_q != 12'hFFF) x_d = x_q + 12'd1;
                    if (in_window) begin
                        if (count < FULL) begin
                            wr_en = 1'b1;
                        end else begin
                            ovf_d   = 1'b1;
                            state_d = DROP;
                        end
                    end
                end
                if (href_fall) begin
                    if (x_d != 12'd0 && y_q != 12'hFFF) y_d = y_q + 12'd1;
                    x_d = '0;
                end
                if (fv_fall) begin
                    done_d  = 1'b1;
                    ok_d    = (y_d >= Y_END) && (state_d != DROP);
                    if (ok_d) cnt_d = oFRAME_CNT + 8'd1;
                    state_d = WAIT_SOF;
                end
            end
            DROP: begin
                if (fv_fall) begin
                    done_d  = 1'b1;
                    ok_d    = 1'b0;
                    state_d = WAIT_SOF;
                end
            end
        endcase
    end

    // State, position counters and frame status registers.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= WAIT_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            oFRAME_DONE <= 1'b0;
            oFRAME_OK   <= 1'b0;
            oOVERFLOW   <= 1'b0;
            oFRAME_CNT  <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            oFRAME_DONE <= done_d;
            oFRAME_OK   <= ok_d;
            oOVERFLOW   <= ovf_d;
            oFRAME_CNT  <= cnt_d;
        end
    end

    // valid_q rises one cycle after the count leaves zero and drops as soon as the last word is read.
    assign rd_en   = valid_q & m_stream.iREADY;
    assign count_d = count + CW'(wr_en) - CW'(rd_en);

    // FIFO pointers, occupancy and the delayed valid flag.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count   <= count_d;
            valid_q <= (count != '0) && (count_d != '0);
        end
    end

    // Storage array; contents need no reset because valid_q gates everything downstream.
    always_ff @(posedge iCLK) begin
        if (wr_en) mem[wr_ptr] <= wr_word;
    end

    assign head            = valid_q ? mem[rd_ptr] : '0;
    assign m_stream.oDATA  = head[15:0];
    assign m_stream.oEOL   = head[16];
    assign m_stream.oSOF   = head[17];
    assign m_stream.oVALID = valid_q;
endmodule

// File: doc/cmos_frame_cropper.md
Name: cmos_frame_cropper

Overview:
- Sits directly downstream of the CMOS capture stage, in the same CMOS_PCLK domain.
- Consumes its 16-bit RGB565 pixel strobes plus line/frame qualifiers.
- Crops a fixed H x V window and buffers kept pixels in an internal FIFO.
- Presents them on a valid/ready stream with SOF/EOL sideband to the frame-buffer writer, and reports per-frame status (done, ok, overflow, frame count).

Parameters:
- H_START, 0, first kept column (0-based pixel index within a line).
- H_SIZE, 640, kept columns per line; H_START+H_SIZE <= 4095.
- V_START, 0, first kept row (0-based line index within a frame).
- V_SIZE, 480, kept rows per frame; V_START+V_SIZE <= 4095.
- FIFO_DEPTH, 64, buffer entries; power of 2, >= 4.

Ports:
- iCLK, in, 1, pixel clock (CMOS_PCLK domain).
- iRST, in, 1, synchronous active-high reset.
- iFRAME_VALID, in, 1, high for the whole active frame; the falling edge is end of frame.
- iHREF, in, 1, line active; the falling edge is end of line.
- iPIX_EN, in, 1, one-cycle strobe, one per complete 16-bit pixel.
- iPIX_DATA, in, 16, RGB565 pixel, qualified by iPIX_EN.
- oDATA, out, 16, FIFO head pixel.
- oSOF, out, 1, head is the first pixel of a cropped frame.
- oEOL, out, 1, head is the last pixel of a cropped line.
- oVALID, out, 1, FIFO not empty.
- iREADY, in, 1, consumer accepts the head when oVALID && iREADY.
- oFRAME_DONE, out, 1, one-cycle pulse at end of frame (not emitted from WAIT_IDLE or WAIT_SOF).
- oFRAME_OK, out, 1, frame result, updated with oFRAME_DONE.
- oOVERFLOW, out, 1, sticky drop flag; cleared at the next SOF.
- oFRAME_CNT, out, 8, count of OK frames; wraps 255 -> 0.

Behaviour:
- Reset: all outputs 0, FIFO emptied, counters 0, state WAIT_IDLE. Reset mid-frame discards buffered data.
- Edge detect: iFRAME_VALID and iHREF are registered once; rise and fall are derived from the previous and current samples.
- WAIT_IDLE: stay until iFRAME_VALID == 0, then go to WAIT_SOF. This prevents starting on a partial frame.
- WAIT_SOF: on iFRAME_VALID rise go to ACTIVE; x=0, y=0, oOVERFLOW=0.
- ACTIVE:
  - Every iPIX_EN increments x (12-bit, saturates at 4095).
  - iHREF fall: x=0; y increments (saturating) only if x != 0.
  - Kept pixel: H_START <= x < H_START+H_SIZE and V_START <= y < V_START+V_SIZE, with x and y sampled before the increment.
  - Kept pixel is written as {SOF, EOL, data}:
    - SOF = (x==H_START && y==V_START).
    - EOL = (x==H_START+H_SIZE-1).
  - Write accepted iff the FIFO count at cycle start < FIFO_DEPTH. A same-cycle read does not free a slot for that write.
  - Kept pixel with FIFO full: pixel dropped, oOVERFLOW=1, go to DROP.
  - iFRAME_VALID fall: oFRAME_DONE pulse; oFRAME_OK = (y >= V_START+V_SIZE); go to WAIT_SOF. If OK, oFRAME_CNT increments.
- DROP: all pixels ignored, nothing written. On iFRAME_VALID fall: oFRAME_DONE pulse, oFRAME_OK=0, go to WAIT_SOF. Data already in the FIFO still drains normally.
- Simultaneous iFRAME_VALID fall and iPIX_EN: the pixel is processed first (may be written), then frame-end handling applies in the same cycle.
- FIFO: first-word-fall-through.
  - A pixel written at edge n gives oVALID=1 after edge n+1 (one-cycle latency); oDATA/oSOF/oEOL are stable while oVALID && !iREADY.
  - Simultaneous read and write with the FIFO non-empty: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
- oVALID never asserts with stale data after reset. Reads with oVALID==0 are ignored.

Test Plan (H_START=2, H_SIZE=4, V_START=1, V_SIZE=2, FIFO_DEPTH=8 unless noted):
1. Basic crop: 4 lines x 8 pixels, data = {y[7:0], x[7:0]}, iREADY=1 -> exactly 8 words out: 0x0102..0x0105 then 0x0202..0x0205.
   - oSOF only on 0x0102; oEOL on 0x0105 and 0x0205.
   - oFRAME_DONE pulse, oFRAME_OK=1, oFRAME_CNT=1.
2. Backpressure/overflow: same frame with iREADY=0 -> the first 8 kept pixels are stored; the 9th kept pixel cannot exist, so use V_SIZE=3 instead.
   - 9th kept pixel is dropped; oOVERFLOW=1.
   - Frame end gives oFRAME_OK=0, oFRAME_CNT unchanged.
   - With iREADY then raised, exactly 8 words drain in order.
3. Short frame: iFRAME_VALID falls after 2 lines -> oFRAME_DONE with oFRAME_OK=0; only row-1 words (0x0102..0x0105) output.
4. Start mid-frame: release reset with iFRAME_VALID=1 for 3 lines -> no writes, no oFRAME_DONE. The next full frame behaves as scenario 1.
5. Reset mid-frame: assert iRST after 3 kept pixels are buffered -> oVALID=0 on the next cycle and all status is 0. After reset, a full frame gives oFRAME_CNT=1.
6. Throughput: iREADY toggling 1/0 with a pixel every cycle, FIFO_DEPTH=4 -> no word duplicated or lost while the FIFO is not full; the output sequence equals the input kept sequence.
